// File: rtl/kmeans_k2n2_centroid_update_if.sv
// Bus between the k2n2 accumulator (master) and the centroid update stage (slave).
interface kmeans_k2n2_centroid_update_if #(
    parameter int unsigned data_width = 16,
    parameter int unsigned sum_width  = 24,
    parameter int unsigned cnt_width  = 9
);
    logic                  start;
    logic [sum_width-1:0]  sum0_d0;
    logic [sum_width-1:0]  sum0_d1;
    logic [sum_width-1:0]  sum1_d0;
    logic [sum_width-1:0]  sum1_d1;
    logic [cnt_width-1:0]  cnt0;
    logic [cnt_width-1:0]  cnt1;
    logic [data_width-1:0] k0_0;
    logic [data_width-1:0] k0_1;
    logic [data_width-1:0] k1_0;
    logic [data_width-1:0] k1_1;
    logic [data_width-1:0] k0_0_n;
    logic [data_width-1:0] k0_1_n;
    logic [data_width-1:0] k1_0_n;
    logic [data_width-1:0] k1_1_n;
    logic                  up_centroids;
    logic                  converged;
    logic                  busy;
    logic [15:0]           iter_count;

    modport master (
        output start, sum0_d0, sum0_d1, sum1_d0, sum1_d1, cnt0, cnt1,
               k0_0, k0_1, k1_0, k1_1,
        input  k0_0_n, k0_1_n, k1_0_n, k1_1_n, up_centroids, converged,
               busy, iter_count
    );

    modport slave (
        input  start, sum0_d0, sum0_d1, sum1_d0, sum1_d1, cnt0, cnt1,
               k0_0, k0_1, k1_0, k1_1,
        output k0_0_n, k0_1_n, k1_0_n, k1_1_n, up_centroids, converged,
               busy, iter_count
    );
endinterface

// File: rtl/kmeans_k2n2_centroid_update.sv
// k2n2 k-means centroid update: snapshots per-cluster sums/counts, divides each
// sum by its count with one shared serial restoring divider, flags convergence.
module kmeans_k2n2_centroid_update #(
    parameter int unsigned data_width = 16,
    parameter int unsigned sum_width  = 24,
    parameter int unsigned cnt_width  = 9,
    parameter int unsigned conv_thr   = 0
) (
    input  logic clk,
    input  logic rst,
    kmeans_k2n2_centroid_update_if.slave bus
);

    localparam int unsigned rem_width = cnt_width + 1;
    localparam int unsigned bit_width = $clog2(sum_width);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        DIV  = 3'd2,
        WR   = 3'd3,
        CMP  = 3'd4,
        UPD  = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    // Snapshot of the accumulator results and the centroids they are compared to
    logic [sum_width-1:0]  snap_sum_q [4];
    logic [cnt_width-1:0]  snap_cnt0_q;
    logic [cnt_width-1:0]  snap_cnt1_q;
    logic [data_width-1:0] old_q      [4];

    // Divider state; dvd_q shifts the dividend out and the quotient in
    logic [sum_width-1:0]  dvd_q;
    logic [rem_width-1:0]  rem_q;
    logic [rem_width-1:0]  dsr_q;
    logic [bit_width-1:0]  bit_q;
    logic [1:0]            idx_q;

    // Registered outputs
    logic [data_width-1:0] kn_q [4];
    logic                  up_q;
    logic                  conv_q;
    logic                  busy_q;
    logic [15:0]           iter_q;

    // Control decodes
    logic snap_c;
    logic load_c;
    logic div_c;
    logic wr_c;
    logic cmp_c;

    // Datapath combinational values
    logic [sum_width-1:0]  sel_sum_c;
    logic [cnt_width-1:0]  sel_cnt_c;
    logic [rem_width-1:0]  shift_c;
    logic                  ge_c;
    logic [rem_width-1:0]  rem_step_c;
    logic [data_width-1:0] result_c;
    logic [data_width-1:0] diff_c;
    logic                  conv_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start outside IDLE is dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    state_d = DIV;
            DIV:     if (bit_q == '0) state_d = WR;
            WR:      state_d = (idx_q == 2'd3) ? CMP : LOAD;
            CMP:     state_d = UPD;
            UPD:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/control decode from the current state
    always_comb begin
        snap_c = 1'b0;
        load_c = 1'b0;
        div_c  = 1'b0;
        wr_c   = 1'b0;
        cmp_c  = 1'b0;
        case (state_q)
            IDLE:    snap_c = bus.start;
            LOAD:    load_c = 1'b1;
            DIV:     div_c  = 1'b1;
            WR:      wr_c   = 1'b1;
            CMP:     cmp_c  = 1'b1;
            default: ;
        endcase
    end

    // Operand select, one restoring step, result saturation/empty-cluster fallback
    always_comb begin
        sel_sum_c  = snap_sum_q[idx_q];
        sel_cnt_c  = idx_q[1] ? snap_cnt1_q : snap_cnt0_q;
        shift_c    = rem_width'({rem_q, dvd_q[sum_width-1]});
        ge_c       = (shift_c >= dsr_q);
        rem_step_c = ge_c ? (shift_c - dsr_q) : shift_c;
        if (sel_cnt_c == '0) begin
            result_c = old_q[idx_q];
        end else if (|dvd_q[sum_width-1:data_width]) begin
            result_c = '1;
        end else begin
            result_c = dvd_q[data_width-1:0];
        end
    end

    // Convergence: every coordinate moved by at most conv_thr
    always_comb begin
        conv_c = 1'b1;
        diff_c = '0;
        for (int j = 0; j < 4; j++) begin
            diff_c = (kn_q[j] >= old_q[j]) ? (kn_q[j] - old_q[j]) : (old_q[j] - kn_q[j]);
            if (diff_c > data_width'(conv_thr)) conv_c = 1'b0;
        end
    end

    // Snapshot, divider and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 4; j++) begin
                snap_sum_q[j] <= '0;
                old_q[j]      <= '0;
                kn_q[j]       <= '0;
            end
            snap_cnt0_q <= '0;
            snap_cnt1_q <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            dsr_q       <= '0;
            bit_q       <= '0;
            idx_q       <= '0;
            up_q        <= 1'b0;
            conv_q      <= 1'b0;
            busy_q      <= 1'b0;
            iter_q      <= '0;
        end else begin
            busy_q <= (state_d != IDLE);
            up_q   <= cmp_c;
            if (snap_c) begin
                snap_sum_q[0] <= bus.sum0_d0;
                snap_sum_q[1] <= bus.sum0_d1;
                snap_sum_q[2] <= bus.sum1_d0;
                snap_sum_q[3] <= bus.sum1_d1;
                snap_cnt0_q   <= bus.cnt0;
                snap_cnt1_q   <= bus.cnt1;
                old_q[0]      <= bus.k0_0;
                old_q[1]      <= bus.k0_1;
                old_q[2]      <= bus.k1_0;
                old_q[3]      <= bus.k1_1;
                idx_q         <= '0;
            end
            if (load_c) begin
                dvd_q <= sel_sum_c;
                dsr_q <= rem_width'(sel_cnt_c);
                rem_q <= '0;
                bit_q <= bit_width'(sum_width - 1);
            end
            if (div_c) begin
                rem_q <= rem_step_c;
                dvd_q <= {dvd_q[sum_width-2:0], ge_c};
                bit_q <= bit_q - bit_width'(1);
            end
            if (wr_c) begin
                kn_q[idx_q] <= result_c;
                idx_q       <= idx_q + 2'd1;
            end
            if (cmp_c) begin
                conv_q <= conv_c;
                iter_q <= iter_q + 16'd1;
            end
        end
    end

    assign bus.k0_0_n       = kn_q[0];
    assign bus.k0_1_n       = kn_q[1];
    assign bus.k1_0_n       = kn_q[2];
    assign bus.k1_1_n       = kn_q[3];
    assign bus.up_centroids = up_q;
    assign bus.converged    = conv_q;
    assign bus.busy         = busy_q;
    assign bus.iter_count   = iter_q;

endmodule

// File: tb/tb_kmeans_k2n2_centroid_update.sv
// Directed bench for kmeans_k2n2_centroid_update; dut0 uses conv_thr=0, dut1 conv_thr=1.
module tb_kmeans_k2n2_centroid_update;

    localparam int unsigned DW = 16;
    localparam int unsigned SW = 24;
    localparam int unsigned CW = 9;
    localparam int LAT = 106;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    kmeans_k2n2_centroid_update_if #(.data_width(DW), .sum_width(SW), .cnt_width(CW)) m0 ();
    kmeans_k2n2_centroid_update_if #(.data_width(DW), .sum_width(SW), .cnt_width(CW)) m1 ();

    kmeans_k2n2_centroid_update #(.data_width(DW), .sum_width(SW), .cnt_width(CW), .conv_thr(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (m0)
    );

    kmeans_k2n2_centroid_update #(.data_width(DW), .sum_width(SW), .cnt_width(CW), .conv_thr(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (m1)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_iter     = 0;

    task automatic set_inputs(input logic [SW-1:0] s00, input logic [SW-1:0] s01,
                              input logic [SW-1:0] s10, input logic [SW-1:0] s11,
                              input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                              input logic [DW-1:0] o00, input logic [DW-1:0] o01,
                              input logic [DW-1:0] o10, input logic [DW-1:0] o11);
        m0.sum0_d0 = s00; m0.sum0_d1 = s01; m0.sum1_d0 = s10; m0.sum1_d1 = s11;
        m0.cnt0 = c0; m0.cnt1 = c1;
        m0.k0_0 = o00; m0.k0_1 = o01; m0.k1_0 = o10; m0.k1_1 = o11;
        m1.sum0_d0 = s00; m1.sum0_d1 = s01; m1.sum1_d0 = s10; m1.sum1_d1 = s11;
        m1.cnt0 = c0; m1.cnt1 = c1;
        m1.k0_0 = o00; m1.k0_1 = o01; m1.k1_0 = o10; m1.k1_1 = o11;
    endtask

    task automatic drive_start(input logic v);
        m0.start = v;
        m1.start = v;
    endtask

    // Pulse start, optionally pulse it again while busy, wait (bounded) for up_centroids.
    // lat = cycle of up_centroids with LOAD as cycle 1, or -1 on timeout.
    task automatic run_update(input int pulse_at, output int lat, output logic busy1);
        lat   = -1;
        busy1 = 1'b0;
        @(negedge clk);
        drive_start(1'b1);
        @(posedge clk);
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) begin
                drive_start(1'b0);
                busy1 = m0.busy;
            end
            if (pulse_at != 0 && n == pulse_at) begin
                set_inputs(24'd900, 24'd900, 24'd900, 24'd900, 9'd9, 9'd9, 16'd9, 16'd9, 16'd9, 16'd9);
                drive_start(1'b1);
            end
            if (pulse_at != 0 && n == pulse_at + 1) drive_start(1'b0);
            if (m0.up_centroids) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [DW*4-1:0] kn;
        set_inputs('0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        drive_start(1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        kn = {m0.k0_0_n, m0.k0_1_n, m0.k1_0_n, m0.k1_1_n};
        tests_run++;
        if (kn !== '0) begin
            tests_failed++;
            $display("FAIL reset_kn: got %h expected 0", kn);
        end
        tests_run++;
        if ({m0.up_centroids, m0.converged, m0.busy, m0.iter_count} !== 19'd0) begin
            tests_failed++;
            $display("FAIL reset_status: up=%b conv=%b busy=%b iter=%0d expected all 0",
                     m0.up_centroids, m0.converged, m0.busy, m0.iter_count);
        end
        rst = 1'b0;
        exp_iter = 0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (m0.busy !== 1'b0 || m1.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: busy0=%b busy1=%b expected 0", m0.busy, m1.busy);
        end
    endtask

    task automatic test_basic;
        int lat;
        logic b1;
        logic [DW*4-1:0] kn;
        set_inputs(24'd300, 24'd600, 24'd1000, 24'd2000, 9'd3, 9'd10, 16'd0, 16'd0, 16'd1, 16'd1);
        run_update(0, lat, b1);
        exp_iter++;
        kn = {m0.k0_0_n, m0.k0_1_n, m0.k1_0_n, m0.k1_1_n};
        tests_run++;
        if (lat !== LAT) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d expected %0d", lat, LAT);
        end
        tests_run++;
        if (b1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_busy_load: got %b expected 1", b1);
        end
        tests_run++;
        if (kn !== {16'd100, 16'd200, 16'd100, 16'd200}) begin
            tests_failed++;
            $display("FAIL basic_centroids: got %h expected %h", kn, {16'd100, 16'd200, 16'd100, 16'd200});
        end
        tests_run++;
        if (m0.converged !== 1'b0 || m1.converged !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_converged: got %b/%b expected 0/0", m0.converged, m1.converged);
        end
        tests_run++;
        if (m0.iter_count !== 16'(exp_iter)) begin
            tests_failed++;
            $display("FAIL basic_iter: got %0d expected %0d", m0.iter_count, exp_iter);
        end
        @(negedge clk);
        tests_run++;
        if (m0.busy !== 1'b0 || m0.up_centroids !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_after_upd: busy=%b up=%b expected 0/0", m0.busy, m0.up_centroids);
        end
    endtask

    task automatic test_trunc_sat;
        int lat;
        logic b1;
        logic [DW*4-1:0] kn;
        set_inputs(24'd10, 24'd20, 24'h100000, 24'd50, 9'd3, 9'd1, 16'd0, 16'd0, 16'd0, 16'd0);
        run_update(0, lat, b1);
        exp_iter++;
        kn = {m0.k0_0_n, m0.k0_1_n, m0.k1_0_n, m0.k1_1_n};
        tests_run++;
        if (lat !== LAT) begin
            tests_failed++;
            $display("FAIL trunc_latency: got %0d expected %0d", lat, LAT);
        end
        tests_run++;
        if (kn !== {16'd3, 16'd6, 16'hFFFF, 16'd50}) begin
            tests_failed++;
            $display("FAIL trunc_sat_centroids: got %h expected %h", kn, {16'd3, 16'd6, 16'hFFFF, 16'd50});
        end
    endtask

    task automatic test_empty_cluster;
        int lat;
        logic b1;
        logic [DW*4-1:0] kn;
        set_inputs(24'd40, 24'd80, 24'd123, 24'd456, 9'd4, 9'd0, 16'd0, 16'd0, 16'd5, 16'd7);
        run_update(0, lat, b1);
        exp_iter++;
        kn = {m0.k0_0_n, m0.k0_1_n, m0.k1_0_n, m0.k1_1_n};
        tests_run++;
        if (lat !== LAT) begin
            tests_failed++;
            $display("FAIL empty_latency: got %0d expected %0d", lat, LAT);
        end
        tests_run++;
        if (kn !== {16'd10, 16'd20, 16'd5, 16'd7}) begin
            tests_failed++;
            $display("FAIL empty_centroids: got %h expected %h", kn, {16'd10, 16'd20, 16'd5, 16'd7});
        end
    endtask

    task automatic test_convergence;
        int lat;
        logic b1;
        logic [DW*4-1:0] kn;
        set_inputs(24'd40, 24'd80, 24'd120, 24'd160, 9'd4, 9'd4, 16'd10, 16'd20, 16'd30, 16'd40);
        run_update(0, lat, b1);
        exp_iter++;
        tests_run++;
        if (m0.converged !== 1'b1 || m1.converged !== 1'b1) begin
            tests_failed++;
            $display("FAIL conv_exact: got %b/%b expected 1/1", m0.converged, m1.converged);
        end
        set_inputs(24'd40, 24'd80, 24'd120, 24'd164, 9'd4, 9'd4, 16'd10, 16'd20, 16'd30, 16'd40);
        run_update(0, lat, b1);
        exp_iter++;
        kn = {m0.k0_0_n, m0.k0_1_n, m0.k1_0_n, m0.k1_1_n};
        tests_run++;
        if (kn !== {16'd10, 16'd20, 16'd30, 16'd41}) begin
            tests_failed++;
            $display("FAIL conv_off_by_one_centroids: got %h expected %h", kn, {16'd10, 16'd20, 16'd30, 16'd41});
        end
        tests_run++;
        if (m0.converged !== 1'b0) begin
            tests_failed++;
            $display("FAIL conv_thr0: got %b expected 0", m0.converged);
        end
        tests_run++;
        if (m1.converged !== 1'b1) begin
            tests_failed++;
            $display("FAIL conv_thr1: got %b expected 1", m1.converged);
        end
        tests_run++;
        if (m0.iter_count !== 16'(exp_iter)) begin
            tests_failed++;
            $display("FAIL conv_iter: got %0d expected %0d", m0.iter_count, exp_iter);
        end
    endtask

    task automatic test_start_while_busy;
        int lat;
        int extra;
        logic b1;
        logic [DW*4-1:0] kn;
        set_inputs(24'd300, 24'd600, 24'd1000, 24'd2000, 9'd3, 9'd10, 16'd0, 16'd0, 16'd1, 16'd1);
        run_update(50, lat, b1);
        exp_iter++;
        kn = {m0.k0_0_n, m0.k0_1_n, m0.k1_0_n, m0.k1_1_n};
        tests_run++;
        if (lat !== LAT) begin
            tests_failed++;
            $display("FAIL busy_start_latency: got %0d expected %0d", lat, LAT);
        end
        tests_run++;
        if (kn !== {16'd100, 16'd200, 16'd100, 16'd200}) begin
            tests_failed++;
            $display("FAIL busy_start_centroids: got %h expected %h", kn, {16'd100, 16'd200, 16'd100, 16'd200});
        end
        extra = 0;
        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            if (m0.up_centroids === 1'b1 || m0.busy === 1'b1) extra++;
        end
        tests_run++;
        if (extra !== 0) begin
            tests_failed++;
            $display("FAIL busy_start_queued: got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic b1;
        logic [DW*4-1:0] kn;
        set_inputs(24'd40, 24'd80, 24'd120, 24'd160, 9'd4, 9'd4, 16'd0, 16'd0, 16'd0, 16'd0);
        run_update(0, lat, b1);
        exp_iter++;
        set_inputs(24'd300, 24'd600, 24'd1000, 24'd2000, 9'd3, 9'd10, 16'd0, 16'd0, 16'd1, 16'd1);
        run_update(0, lat, b1);
        exp_iter++;
        kn = {m0.k0_0_n, m0.k0_1_n, m0.k1_0_n, m0.k1_1_n};
        tests_run++;
        if (lat !== LAT) begin
            tests_failed++;
            $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT);
        end
        tests_run++;
        if (kn !== {16'd100, 16'd200, 16'd100, 16'd200} || m0.iter_count !== 16'(exp_iter)) begin
            tests_failed++;
            $display("FAIL b2b_result: got %h iter %0d expected %h iter %0d",
                     kn, m0.iter_count, {16'd100, 16'd200, 16'd100, 16'd200}, exp_iter);
        end
    endtask

    task automatic test_reset_mid_div;
        int lat;
        int ups;
        logic b1;
        logic [DW*4-1:0] kn;
        set_inputs(24'd40, 24'd80, 24'd120, 24'd160, 9'd4, 9'd4, 16'd0, 16'd0, 16'd0, 16'd0);
        @(negedge clk);
        drive_start(1'b1);
        @(posedge clk);
        ups = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) drive_start(1'b0);
            if (m0.up_centroids === 1'b1) ups++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_iter = 0;
        kn = {m0.k0_0_n, m0.k0_1_n, m0.k1_0_n, m0.k1_1_n};
        tests_run++;
        if (kn !== '0 || {m0.up_centroids, m0.converged, m0.busy, m0.iter_count} !== 19'd0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: kn=%h up=%b conv=%b busy=%b iter=%0d expected all 0",
                     kn, m0.up_centroids, m0.converged, m0.busy, m0.iter_count);
        end
        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            if (m0.up_centroids === 1'b1) ups++;
        end
        tests_run++;
        if (ups !== 0) begin
            tests_failed++;
            $display("FAIL midreset_no_up: got %0d strobes expected 0", ups);
        end
        set_inputs(24'd10, 24'd20, 24'h100000, 24'd50, 9'd3, 9'd1, 16'd0, 16'd0, 16'd0, 16'd0);
        run_update(0, lat, b1);
        exp_iter++;
        kn = {m0.k0_0_n, m0.k0_1_n, m0.k1_0_n, m0.k1_1_n};
        tests_run++;
        if (lat !== LAT) begin
            tests_failed++;
            $display("FAIL midreset_fresh_latency: got %0d expected %0d", lat, LAT);
        end
        tests_run++;
        if (kn !== {16'd3, 16'd6, 16'hFFFF, 16'd50} || m0.iter_count !== 16'(exp_iter)) begin
            tests_failed++;
            $display("FAIL midreset_fresh_result: got %h iter %0d expected %h iter %0d",
                     kn, m0.iter_count, {16'd3, 16'd6, 16'hFFFF, 16'd50}, exp_iter);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_start(1'b0);
        test_reset();
        test_basic();
        test_trunc_sat();
        test_empty_cluster();
        test_convergence();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/kmeans_k2n2_centroid_update.md
Name: kmeans_k2n2_centroid_update

Overview:
- Downstream stage of the k2n2 k-means pipeline/accumulator; runs once per iteration, after the accumulator has finished one pass over the input data.
- Snapshots the per-cluster coordinate sums and member counts, then divides each sum by its count with one shared serial restoring divider.
- Outputs the new centroids (k0_0_n, k0_1_n, k1_0_n, k1_1_n) with a one-cycle up_centroids strobe, and flags convergence against the current centroids.

Parameters:
- data_width, 16, width of one coordinate and of each centroid value.
- sum_width, 24, width of each accumulated coordinate sum; data_width + n_input_data_b_depth.
- cnt_width, 9, width of the per-cluster member counters; n_input_data_b_depth+1.
- conv_thr, 0, maximum per-coordinate |new-old| that still counts as converged.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request from the accumulator: sums and counts are final.
- sum0_d0, sum0_d1  in  sum_width each  cluster 0 coordinate sums.
- sum1_d0, sum1_d1  in  sum_width each  cluster 1 coordinate sums.
- cnt0, cnt1  in  cnt_width each  member counts of cluster 0 / cluster 1.
- k0_0, k0_1, k1_0, k1_1  in  data_width each  current centroids.
- k0_0_n, k0_1_n, k1_0_n, k1_1_n  out  data_width each  new centroids, registered.
- up_centroids  out  1  one-cycle strobe: new centroids valid, load them.
- converged  out  1  registered; valid from the up_centroids cycle until the next start is accepted.
- busy  out  1  high from the LOAD of operand 0 through UPD.
- iter_count  out  16  count of completed updates, wraps at 2^16.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - all *_n outputs = 0;
  - up_centroids = 0, converged = 0, busy = 0, iter_count = 0;
  - FSM = IDLE.
- Reset takes priority in any state. Reset mid-operation aborts the run; no up_centroids is issued.
- FSM states: IDLE, LOAD, DIV, WR, CMP, UPD.
- IDLE:
  - start=1 snapshots all 4 sums, both counts and all 4 current centroids into internal registers; next state LOAD with operand index i=0.
  - start while not IDLE is ignored; no queuing.
- Operand order: i=0 sum0_d0/cnt0, i=1 sum0_d1/cnt0, i=2 sum1_d0/cnt1, i=3 sum1_d1/cnt1.
- LOAD (1 cycle): dividend <- sum_i, divisor <- cnt_i zero-extended, remainder <- 0, bit counter <- sum_width-1.
- DIV (sum_width cycles): one restoring step per cycle, MSB first.
  - remainder is cnt_width+1 bits wide.
  - Quotient bit = 1 when the shifted remainder >= divisor.
  - Exit to WR after the bit-0 step.
- WR (1 cycle): writes the result into the *_n register for index i.
  - If the count is 0, the result is the snapshotted old centroid.
  - Otherwise the result is the quotient (truncating division). A quotient above 2^data_width-1 saturates to all ones.
  - Then i++. After i=3, next state is CMP; otherwise LOAD.
- CMP (1 cycle): converged <- 1 when every |*_n - old| <= conv_thr (unsigned compare on both orderings), else 0.
- UPD (1 cycle): up_centroids=1, iter_count++, then IDLE.
- Latency is fixed regardless of zero counts. With LOAD as cycle 1 after the start edge:
  - up_centroids is asserted in cycle 4*(sum_width+2)+2, i.e. 106 for the defaults;
  - start may be accepted again in the cycle after UPD.
- The *_n outputs change only in WR and hold otherwise. Consumers sample them when up_centroids=1.
- Arithmetic: unsigned only; no rounding.

Test Plan:
1. Basic update: cnt0=3, sums 300/600; cnt1=10, sums 1000/2000; old centroids 0,0,1,1; start 1 cycle -> up_centroids high exactly 106 cycles later; *_n = 100,200,100,200; converged=0; iter_count=1; busy low next cycle.
2. Truncation: sum0_d0=10, cnt0=3 -> k0_0_n=3. Saturation: sum1_d0=0x100000, cnt1=1 -> k1_0_n=0xFFFF.
3. Empty cluster: cnt1=0, old k1=5,7; k0 sums 40/80, cnt0=4 -> k0=10,20; k1_0_n=5, k1_1_n=7; latency still 106.
4. Convergence: old centroids 10,20,30,40; sums 40,80,120,160 with cnt0=cnt1=4 -> converged=1. Repeat with sum1_d1=164 and conv_thr=0 -> converged=0; same stimulus with conv_thr=1 -> converged=1.
5. Start while busy: pulse start at cycle 50 with different sums -> ignored; results match the first snapshot; single up_centroids.
6. Reset mid-DIV at cycle 30: all outputs 0 next cycle, no up_centroids. A fresh start afterwards completes normally in 106 cycles.
